// File: rtl/ziggurat_sample_ctrl_if.sv
// Generator candidate path and sample read port shared by the controller
// (master) and the generator/consumer side (slave).
interface ziggurat_sample_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              gen_en;
  logic              gen_valid;
  logic [DATA_W-1:0] gen_data;
  logic              gen_invalid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output gen_en, rd_data, rd_valid,
    input  gen_valid, gen_data, gen_invalid, rd_ready
  );

  modport slave (
    input  gen_en, rd_data, rd_valid,
    output gen_valid, gen_data, gen_invalid, rd_ready
  );
endinterface

// File: rtl/ziggurat_sample_ctrl.sv
// Run sequencer for the Ziggurat Gaussian generator: keeps accepted
// candidates in a FWFT FIFO, stops at a programmed count, keeps run statistics.
module ziggurat_sample_ctrl #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 24,
  parameter int REJ_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [CNT_W-1:0]      i_target_cnt,
  ziggurat_sample_ctrl_if.master bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_accept_cnt,
  output logic [REJ_W-1:0]      o_reject_cnt,
  output logic                  o_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [AW:0]       r_count;
  logic [CNT_W-1:0]  r_target, r_acc;
  logic [REJ_W-1:0]  r_rej;
  logic              r_ovf;

  logic              w_start_ok, w_below, w_full, w_pop, w_cand;
  logic              w_rej, w_push, w_drop, w_active;
  logic [AW:0]       w_count_nxt;

  // An abort arriving together with start only cancels it from IDLE.
  assign w_start_ok  = i_start & (((r_state == S_IDLE) & ~i_abort) | (r_state == S_DONE));
  assign w_active    = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_below     = r_acc < r_target;
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_pop       = bus.rd_valid & bus.rd_ready;
  assign w_cand      = bus.gen_valid & w_active & w_below;
  assign w_rej       = w_cand & bus.gen_invalid;
  assign w_push      = w_cand & ~bus.gen_invalid & (~w_full | w_pop);
  assign w_drop      = w_cand & ~bus.gen_invalid & w_full & ~w_pop;
  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // Two free slots cover the candidate already in flight from last cycle.
  assign bus.gen_en   = (r_state == S_RUN) & ~i_abort & w_below &
                        (r_count <= (AW+1)'(FIFO_DEPTH - 2));
  assign bus.rd_valid = r_count != '0;
  assign bus.rd_data  = r_mem[r_rptr];

  assign o_busy       = w_active;
  assign o_done       = r_state == S_DONE;
  assign o_accept_cnt = r_acc;
  assign o_reject_cnt = r_rej;
  assign o_overflow   = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_state_nxt = (i_target_cnt == '0) ? S_DONE : S_RUN;
      S_RUN:          if ((r_acc == r_target) | i_abort) w_state_nxt = S_DRAIN;
      S_DRAIN:        if (w_count_nxt == '0) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_target <= '0;
      r_acc    <= '0;
      r_rej    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_target <= i_target_cnt;
        r_acc    <= '0;
        r_rej    <= '0;
        r_ovf    <= 1'b0;
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_count  <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
          r_acc  <= r_acc + CNT_W'(1);
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        if (w_rej && (r_rej != '1)) r_rej <= r_rej + REJ_W'(1);
        if (w_drop) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !w_start_ok) r_mem[r_wptr] <= bus.gen_data;
  end
endmodule

// File: tb/tb_ziggurat_sample_ctrl.sv
// Directed bench for ziggurat_sample_ctrl: a reactive generator model answers
// gen_en one cycle later; a monitor pops expected samples from a scoreboard.
module tb_ziggurat_sample_ctrl;
  localparam int DW = 32;
  localparam int CW = 24;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [CW-1:0] target;
  logic          busy, done, overflow;
  logic [CW-1:0] acc;
  logic [RW-1:0] rej;

  ziggurat_sample_ctrl_if #(.DATA_W(DW)) zif ();

  ziggurat_sample_ctrl #(.DATA_W(DW), .FIFO_DEPTH(8), .CNT_W(CW), .REJ_W(RW)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
    .i_target_cnt(target), .bus(zif),
    .o_busy(busy), .o_done(done), .o_accept_cnt(acc),
    .o_reject_cnt(rej), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          test_id = 0;
  int          gen_mode = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 1 rejects candidates 1 and 4; mode 2 rejects everything
  function automatic logic inv_of(input int m, input int idx);
    case (m)
      1:       return (idx == 1) || (idx == 4);
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // generator: candidate appears one cycle after gen_en
  initial begin
    int   gidx = 0;
    int   last_id = 0;
    logic en_s;
    zif.gen_valid   = 1'b0;
    zif.gen_invalid = 1'b0;
    zif.gen_data    = '0;
    forever begin
      @(posedge clk);
      en_s = zif.gen_en;
      if (test_id != last_id) begin
        gidx    = 0;
        last_id = test_id;
      end
      #1;
      zif.gen_valid   = en_s;
      zif.gen_invalid = inv_of(gen_mode, gidx);
      zif.gen_data    = 32'h1000 + gidx;
      if (en_s) gidx++;
    end
  end

  // monitor: every pop is compared against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && zif.rd_valid && zif.rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %0h expected no sample", zif.rd_data);
        end else begin
          chk("rd_data", zif.rd_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] t);
    target = t;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic wait_acc(input logic [CW-1:0] n, input int budget);
    int k = 0;
    @(negedge clk);
    while (acc != n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_acc", 32'(acc), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; target = '0;
    zif.rd_ready = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(zif.rd_valid), 0);
    chk("rst_gen_en", 32'(zif.gen_en), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_rej", 32'(rej), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    tick(1);

    // T1: reset in the middle of a run with samples queued
    test_id = 1; gen_mode = 0;
    pulse_start(10);
    wait_acc(5, 50);
    reset = 1'b1;
    tick(1);
    chk("t1_rd_valid", 32'(zif.rd_valid), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_acc", 32'(acc), 0);
    chk("t1_rej", 32'(rej), 0);
    chk("t1_gen_en", 32'(zif.gen_en), 0);
    reset = 1'b0;
    tick(1);

    // T2: mixed valid/invalid candidates, consumer always ready
    test_id = 2; gen_mode = 1;
    zif.rd_ready = 1'b1;
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1002);
    exp_q.push_back(32'h1003); exp_q.push_back(32'h1005);
    pulse_start(4);
    wait_done(60);
    chk("t2_acc", 32'(acc), 4);
    chk("t2_rej", 32'(rej), 2);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_ovf", 32'(overflow), 0);

    // T3: stalled consumer fills the FIFO without overflow, then drains
    test_id = 3; gen_mode = 0;
    zif.rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) exp_q.push_back(32'h1000 + i);
    pulse_start(20);
    tick(20);
    chk("t3_acc_peak", 32'(acc), 8);
    chk("t3_gen_en", 32'(zif.gen_en), 0);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_busy", 32'(busy), 1);
    zif.rd_ready = 1'b1;
    wait_done(100);
    chk("t3_acc", 32'(acc), 20);
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_ovf_end", 32'(overflow), 0);

    // T4: zero target, then start+abort together from IDLE
    test_id = 4;
    pulse_start(0);
    chk("t4_done", 32'(done), 1);
    chk("t4_gen_en", 32'(zif.gen_en), 0);
    tick(3);
    chk("t4_done_hold", 32'(done), 1);
    chk("t4_gen_en_hold", 32'(zif.gen_en), 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    target = 5; start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("t4_sa_busy", 32'(busy), 0);
    chk("t4_sa_done", 32'(done), 0);
    tick(2);
    chk("t4_sa_gen_en", 32'(zif.gen_en), 0);
    chk("t4_sa_busy2", 32'(busy), 0);

    // T5: abort with samples still queued
    test_id = 5; gen_mode = 0;
    zif.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + i);
    pulse_start(10);
    wait_acc(3, 50);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 1);
    chk("t5_gen_en", 32'(zif.gen_en), 0);
    tick(5);
    chk("t5_acc", 32'(acc), 4);
    chk("t5_not_done", 32'(done), 0);
    chk("t5_rd_valid", 32'(zif.rd_valid), 1);
    zif.rd_ready = 1'b1;
    wait_done(30);
    chk("t5_acc_end", 32'(acc), 4);
    chk("t5_q_empty", exp_q.size(), 0);

    // T6: reject counter saturation and clear on restart
    test_id = 6; gen_mode = 2;
    pulse_start(1);
    tick(70010);
    chk("t6_rej_sat", 32'(rej), 32'hFFFF);
    chk("t6_acc", 32'(acc), 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_done(10);
    test_id = 7; gen_mode = 0;
    exp_q.push_back(32'h1000);
    pulse_start(1);
    chk("t6_rej_clr", 32'(rej), 0);
    chk("t6_busy", 32'(busy), 1);
    wait_done(30);
    chk("t6_acc_end", 32'(acc), 1);

    tick(2);
    chk("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
